tp_serial_rx: RTL and testbench

Debug command receiver for the test-point input pins. It samples a 3-wire serial stream (chip-select, clock, data) driven by a bench instrument onto input-configured test-point pins. It deframes fixed-length words and presents each good word to fabric as a held data word plus a one-cycle strobe. It sits in the same clock domain as the test-point output logic and is its inbound counterpart.

---
 rtl/tp_serial_rx.sv | 151 +++++++++++++++
 tb/tb_tp_serial_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tp_serial_rx.sv
// rtl/tp_serial_rx.sv - test-point 3-wire serial command receiver (CS_B/SCK/SDI deframer)
// Optional odd-parity bit after the payload: define TP_RX_PARITY_EN.
module tp_serial_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  TP_CS_B,
  input  logic                  TP_SCK,
  input  logic                  TP_SDI,
  output logic [FRAME_BITS-1:0] DATA,
  output logic                  VLD,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [7:0]            FRM_CNT
);

`ifdef TP_RX_PARITY_EN
  localparam int NBITS = FRAME_BITS + 1;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam int BCW = $clog2(NBITS + 2);
  localparam int WUW = $clog2(SYNC_STAGES + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(NBITS);
  localparam logic [BCW-1:0] BC_SAT  = BCW'(NBITS + 1);
  localparam logic [15:0]    TMO_LIM = 16'(TIMEOUT);
  localparam logic [WUW-1:0] WU_DONE = WUW'(SYNC_STAGES);

  typedef enum logic [1:0] {WAIT_CS, IDLE, SHIFT, CHECK} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   cs_d, sck_d, sdi_d;
  logic                   cs_s, sck_s, cs_rise, sck_rise;
  logic [WUW-1:0]         wu_cnt;
  logic [NBITS-1:0]       sr;
  logic [BCW-1:0]         bit_cnt;
  logic [15:0]            tmo_cnt;
  logic                   clr, shift_en, vld_nxt, err_nxt, parity_ok, frame_ok;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign BUSY     = (state == SHIFT);

`ifdef TP_RX_PARITY_EN
  assign parity_ok = ^sr;
`else
  assign parity_ok = 1'b1;
`endif
  assign frame_ok = (bit_cnt == BC_FULL) && parity_ok;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      cs_sync  <= '1;
      sck_sync <= '1;
      sdi_sync <= '1;
      cs_d     <= 1'b1;
      sck_d    <= 1'b1;
      sdi_d    <= 1'b1;
      wu_cnt   <= '0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], TP_CS_B};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], TP_SCK};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], TP_SDI};
      cs_d     <= cs_s;
      sck_d    <= sck_s;
      sdi_d    <= sdi_sync[SYNC_STAGES-1];
      if (wu_cnt != WU_DONE) wu_cnt <= wu_cnt + WUW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) state <= WAIT_CS;
    else        state <= state_nxt;
  end

  // The synchronizers come out of reset at the CS_B idle level, so WAIT_CS only
  // trusts cs_s once the real pin value has had time to reach the last stage.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      WAIT_CS: if (wu_cnt == WU_DONE && cs_s) state_nxt = IDLE;
      IDLE: begin
        if (!cs_s) begin
          clr       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = CHECK;
        end else if (tmo_cnt == TMO_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_CS;
        end else if (sck_rise) begin
          shift_en  = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (frame_ok) vld_nxt = 1'b1;
        else          err_nxt = 1'b1;
      end
      default: state_nxt = WAIT_CS;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      sr      <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
      DATA    <= '0;
      VLD     <= 1'b0;
      ERR     <= 1'b0;
      FRM_CNT <= '0;
    end else begin
      VLD <= vld_nxt;
      ERR <= err_nxt;
      if (clr) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        sr <= {sr[NBITS-2:0], sdi_d};
        if (bit_cnt != BC_SAT) bit_cnt <= bit_cnt + BCW'(1);
      end
      if (clr || shift_en)
        tmo_cnt <= '0;
      else if (state == SHIFT && tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (vld_nxt) begin
`ifdef TP_RX_PARITY_EN
        DATA <= sr[NBITS-1:1];
`else
        DATA <= sr[FRAME_BITS-1:0];
`endif
        FRM_CNT <= FRM_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tp_serial_rx.sv
// tb/tb_tp_serial_rx.sv - scoreboard bench for tp_serial_rx with a frame-level reference model
// Honours TP_RX_PARITY_EN the same way as the design.
module tb_tp_serial_rx;
  localparam int FB  = 16;
  localparam int TMO = 255;
  localparam int SS  = 2;
`ifdef TP_RX_PARITY_EN
  localparam int NB  = FB + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = FB;
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0, rst_b = 1'b0, cs_b = 1'b1, sck = 1'b0, sdi = 1'b0;
  logic [FB-1:0] data;
  logic          vld, err, busy;
  logic [7:0]    frm_cnt;

  tp_serial_rx #(.FRAME_BITS(FB), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
    .CLK(clk), .RST_B(rst_b), .TP_CS_B(cs_b), .TP_SCK(sck), .TP_SDI(sdi),
    .DATA(data), .VLD(vld), .ERR(err), .BUSY(busy), .FRM_CNT(frm_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] d;
    logic [7:0]    cnt;
    int            at;
  } exp_t;

  exp_t          q[$];
  int            errors = 0, checks = 0, vld_seen = 0;
  logic [FB-1:0] m_data = '0;
  logic [7:0]    m_cnt  = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: a frame is good when exactly NB bits arrived and, with
  // parity, the XOR over every received bit is 1; payload is the first FB bits.
  task automatic expect_frame(input logic [31:0] word, input int n, input int at);
    exp_t        e;
    logic [31:0] w;
    bit          ok;
    w  = (n >= 32) ? word : (word & ((32'd1 << n) - 32'd1));
    ok = (n == NB);
    if (ok && PAR) ok = ^w;
    if (ok) begin
      m_data = FB'(w >> (NB - FB));
      m_cnt  = m_cnt + 8'd1;
    end
    e.is_err = !ok;
    e.d      = m_data;
    e.cnt    = m_cnt;
    e.at     = at;
    q.push_back(e);
  endtask

  function automatic logic [31:0] mk_good(input logic [FB-1:0] p);
    return PAR ? ((32'(p) << 1) | 32'(~^p)) : 32'(p);
  endfunction

  always @(negedge clk) begin
    if (rst_b && (vld || err)) begin
      exp_t e;
      check("vld_err_exclusive", 64'(vld & err), 64'd0);
      if (vld) vld_seen++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: vld=%0b err=%0b with nothing expected (cycle %0d)", vld, err, cyc);
      end else begin
        e = q.pop_front();
        check("out_kind_err", 64'(err), 64'(e.is_err));
        check("out_cycle", 64'(cyc), 64'(e.at));
        check("out_data", 64'(data), 64'(e.d));
        check("out_frm_cnt", 64'(frm_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits word[n-1:0] MSB first; with coincide the last SCK rise and CS_B rise share a cycle.
  task automatic send_frame(input logic [31:0] word, input int n, input int half, input bit coincide);
    int at;
    at = 0;
    cs_b = 1'b0;
    tick(SS + 2);
    check("busy_in_frame", 64'(busy), 64'd1);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = word[i];
      tick(half);
      sck = 1'b1;
      if (coincide && i == 0) begin
        cs_b = 1'b1;
        at   = cyc;
      end
      tick(half);
      sck = 1'b0;
    end
    if (coincide) begin
      expect_frame(word >> 1, n - 1, at + SS + 2);
    end else begin
      tick(half);
      cs_b = 1'b1;
      expect_frame(word, n, cyc + SS + 2);
    end
    tick(6);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 64'(data), 64'd0);
    check({tag, "_vld"}, 64'(vld), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frm_cnt"}, 64'(frm_cnt), 64'd0);
  endtask

  initial begin
    int last, v0, n, half;
    logic [31:0] w;

    tick(3);
    check_reset_outputs("reset");
    rst_b = 1'b1;
    tick(SS + 4);

    send_frame(mk_good(16'hA5C3), NB, 8, 1'b0);
    send_frame(32'h1234_5, NB - 1, 5, 1'b0);
    send_frame(32'h2_5A5A, NB + 1, 5, 1'b0);

    // SCK stalls after 5 bits: timeout ERR, then the late CS_B rise is silent
    cs_b = 1'b0;
    tick(SS + 2);
    last = 0;
    for (int i = 0; i < 5; i++) begin
      sdi = i[0];
      tick(4);
      sck  = 1'b1;
      last = cyc;
      tick(4);
      sck  = 1'b0;
    end
    expect_frame(32'd0, 0, last + SS + TMO + 2);
    tick(300);
    cs_b = 1'b1;
    tick(8);
    send_frame(mk_good(16'h3C96), NB, 4, 1'b0);

    send_frame(mk_good(16'h0F0F), NB, 4, 1'b1);

    // short CS_B pulse with no clocks is a 0-bit frame
    cs_b = 1'b0;
    tick(3);
    cs_b = 1'b1;
    expect_frame(32'd0, 0, cyc + SS + 2);
    tick(8);

    // reset during bit 8, released with CS_B still low
    w = mk_good(16'hBEEF);
    cs_b = 1'b0;
    tick(SS + 2);
    for (int i = NB - 1; i >= NB - 8; i--) begin
      sdi = w[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    sdi = w[NB - 9];
    tick(4);
    sck = 1'b1;
    tick(2);
    rst_b = 1'b0;
    m_data = '0;
    m_cnt  = '0;
    tick(2);
    check_reset_outputs("mid_reset");
    rst_b = 1'b1;
    tick(2);
    sck = 1'b0;
    for (int i = NB - 10; i >= 0; i--) begin
      sdi = w[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
    cs_b = 1'b1;
    tick(10);
    send_frame(mk_good(16'h0001), NB, 4, 1'b0);

    for (int k = 0; k < 24; k++) begin
      n    = NB + int'($urandom_range(4)) - 2;
      if ($urandom_range(1) == 1) n = NB;
      half = int'($urandom_range(10, 3));
      w    = $urandom;
      if (n == NB && $urandom_range(3) != 0) w = mk_good(FB'(w));
      send_frame(w, n, half, 1'b0);
    end

    v0 = vld_seen;
    for (int k = 0; k < 256; k++) send_frame(mk_good(FB'($urandom)), NB, 3, 1'b0);
    check("vld_pulses_256", 64'(vld_seen - v0), 64'd256);
    check("frm_cnt_after_wrap", 64'(frm_cnt), 64'(m_cnt));

`ifdef TP_RX_PARITY_EN
    send_frame({15'd0, 16'hA5C3, 1'b1}, NB, 5, 1'b0);
    send_frame({15'd0, 16'hA5C3, 1'b0}, NB, 5, 1'b0);
`endif

    tick(10);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
